// File: rtl/sig_frame_pkg.sv
// Shared types and constants for the three-strobe frame decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sig_frame_pkg;

    localparam int NSIG = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    // All-ones value of a w-bit timestamp, meaning "edge not seen in this frame".
    // Callers truncate the result to their timestamp width.
    function automatic logic [31:0] ts_none(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/strobe_edge_det.sv
// Two-flop sampler for one idle-high strobe; reports sampled level and fall/rise pulses.
// Latency: fall/rise valid in the cycle after the posedge that first samples the new level.
// Backpressure: none (free-running).
//
// Ports: clk, rst (sync, active-high), sig (strobe in) -> level, fall, rise.
module strobe_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic fall,
    output logic rise
);

    logic       s_q, s_d;
    logic       p_q, p_d;
    // Arms edge detection only once p_q holds a genuine post-reset sample, so a
    // strobe already low when reset releases is not mistaken for a fresh fall.
    logic [1:0] arm_q, arm_d;

    always_comb begin
        s_d   = sig;
        p_d   = s_q;
        arm_d = {arm_q[0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 1'b1;
            p_q   <= 1'b1;
            arm_q <= 2'b00;
        end else begin
            s_q   <= s_d;
            p_q   <= p_d;
            arm_q <= arm_d;
        end
    end

    assign level = s_q;
    assign fall  = arm_q[1] & p_q & ~s_q;
    assign rise  = arm_q[1] & ~p_q & s_q;

endmodule

// File: rtl/sig_frame_decoder.sv
// Timestamps fall/rise edges of three idle-high strobes per frame, flags errors, emits one record per frame.
// Latency: frm_valid rises 2 posedges after the posedge sampling the completing rise (timeout: same path).
// Backpressure: record and all fields held while frm_valid & ~frm_ready; new edges ignored until accepted.
//
// Ports: clk, rst (sync, active-high), sig1..sig3 strobes, frm_ready in;
//        frm_valid, fall_ts/rise_ts (slice [i*TW +: TW] = sig(i+1)), err_dup, err_timeout, frame_cnt out.
module sig_frame_decoder
    import sig_frame_pkg::*;
#(
    parameter int TW      = 8,
    parameter int TIMEOUT = 63,
    parameter int CW      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig1,
    input  logic              sig2,
    input  logic              sig3,
    input  logic              frm_ready,
    output logic              frm_valid,
    output logic [3*TW-1:0]   fall_ts,
    output logic [3*TW-1:0]   rise_ts,
    output logic              err_dup,
    output logic              err_timeout,
    output logic [CW-1:0]     frame_cnt
);

    localparam logic [TW-1:0] TS_NONE = TW'(ts_none(TW));
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT);

    logic [NSIG-1:0] sig_w;
    logic [NSIG-1:0] fall_w;
    logic [NSIG-1:0] rise_w;
    // Sampled levels are not needed: frame logic works purely on edges.
    logic [NSIG-1:0] unused_level;

    assign sig_w = {sig3, sig2, sig1};

    for (genvar g = 0; g < NSIG; g++) begin : g_det
        strobe_edge_det u_det (
            .clk   (clk),
            .rst   (rst),
            .sig   (sig_w[g]),
            .level (unused_level[g]),
            .fall  (fall_w[g]),
            .rise  (rise_w[g])
        );
    end

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NSIG-1:0]    fall_seen_q, fall_seen_d;
    logic [NSIG-1:0]    rise_seen_q, rise_seen_d;
    logic [3*TW-1:0]    fall_ts_q, fall_ts_d;
    logic [3*TW-1:0]    rise_ts_q, rise_ts_d;
    logic               err_dup_q, err_dup_d;
    logic               err_to_q, err_to_d;
    logic               frm_valid_q, frm_valid_d;
    logic [CW-1:0]      frame_cnt_q, frame_cnt_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fall_seen_d = fall_seen_q;
        rise_seen_d = rise_seen_q;
        fall_ts_d   = fall_ts_q;
        rise_ts_d   = rise_ts_q;
        err_dup_d   = err_dup_q;
        err_to_d    = err_to_q;
        frm_valid_d = frm_valid_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                timer_d     = '0;
                fall_seen_d = '0;
                rise_seen_d = '0;
                if (|fall_w) begin
                    state_d     = ACTIVE;
                    // The next cycle sees edges sampled one posedge after the first low.
                    timer_d     = TW'(1);
                    fall_seen_d = fall_w;
                    for (int i = 0; i < NSIG; i++) begin
                        fall_ts_d[i*TW +: TW] = fall_w[i] ? '0 : TS_NONE;
                        rise_ts_d[i*TW +: TW] = TS_NONE;
                    end
                end
            end

            ACTIVE: begin
                timer_d = timer_q + TW'(1);
                for (int i = 0; i < NSIG; i++) begin
                    if (fall_w[i]) begin
                        if (fall_seen_q[i]) begin
                            err_dup_d = 1'b1;
                        end else begin
                            fall_seen_d[i]        = 1'b1;
                            fall_ts_d[i*TW +: TW] = timer_q;
                        end
                    end
                    // Only the rise closing the first recorded pulse counts.
                    if (rise_w[i] && fall_seen_q[i] && !rise_seen_q[i]) begin
                        rise_seen_d[i]        = 1'b1;
                        rise_ts_d[i*TW +: TW] = timer_q;
                    end
                end
                // Completion is judged on this cycle's updates, so it beats a coincident timeout.
                if (&(fall_seen_d & rise_seen_d)) begin
                    state_d = REPORT;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = REPORT;
                    err_to_d = 1'b1;
                end
            end

            REPORT: begin
                if (!frm_valid_q) begin
                    frm_valid_d = 1'b1;
                end else if (frm_ready) begin
                    frm_valid_d = 1'b0;
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + CW'(1);
                    err_dup_d   = 1'b0;
                    err_to_d    = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fall_seen_q <= '0;
            rise_seen_q <= '0;
            fall_ts_q   <= '1;
            rise_ts_q   <= '1;
            err_dup_q   <= 1'b0;
            err_to_q    <= 1'b0;
            frm_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fall_seen_q <= fall_seen_d;
            rise_seen_q <= rise_seen_d;
            fall_ts_q   <= fall_ts_d;
            rise_ts_q   <= rise_ts_d;
            err_dup_q   <= err_dup_d;
            err_to_q    <= err_to_d;
            frm_valid_q <= frm_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frm_valid   = frm_valid_q;
    assign fall_ts     = fall_ts_q;
    assign rise_ts     = rise_ts_q;
    assign err_dup     = err_dup_q;
    assign err_timeout = err_to_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
